// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and the scan_sequencer.
// The master drives the scan controls; the slave returns decoder select/enable and strobes.
interface scan_sequencer_if #(
    parameter int PRESCALE_W = 4
);
    logic                  run;
    logic                  step;
    logic [2:0]            last;
    logic [PRESCALE_W-1:0] div;
    logic [2:0]            sel;
    logic                  en;
    logic                  tick;
    logic                  wrap;

    modport master (output run, step, last, div, input sel, en, tick, wrap);
    modport slave  (input run, step, last, div, output sel, en, tick, wrap);
endinterface

// File: rtl/scan_sequencer.sv
// Drives a 3-to-8 decoder: prescaled index stepping with wrap at a live 'last',
// a one-cycle blank on every index change, and free-run / single-step modes.
module scan_sequencer #(
    parameter int PRESCALE_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    scan_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

    localparam logic [PRESCALE_W-1:0] CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [2:0]            r_sel;
    logic                  r_en;
    logic                  r_tick;
    logic                  r_wrap;
    logic [PRESCALE_W-1:0] r_cnt;

    logic [2:0]            w_next;
    logic                  w_hit;
    logic                  w_dwell;

    // sel >= last (not ==) so a lowered 'last' sends the next advance to 0.
    assign w_next  = (r_sel >= bus.last) ? 3'd0 : r_sel + 3'd1;
    assign w_hit   = (r_cnt == bus.div);
    assign w_dwell = bus.run && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 3'd0;
            r_en    <= 1'b0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.run) begin
                        r_state <= S_RUN;
                        r_en    <= 1'b1;
                    end else if (bus.step) begin
                        r_state <= S_STEP;
                        r_sel   <= w_next;
                        r_tick  <= 1'b1;
                        r_wrap  <= (w_next == 3'd0);
                        r_en    <= 1'b0;
                    end else begin
                        r_en    <= 1'b0;
                    end
                end
                default: begin
                    // STEP with run high joins the running dwell without clearing count.
                    if (w_dwell) begin
                        r_state <= S_RUN;
                        if (w_hit) begin
                            r_sel  <= w_next;
                            r_tick <= 1'b1;
                            r_wrap <= (w_next == 3'd0);
                            r_en   <= 1'b0;
                            r_cnt  <= '0;
                        end else begin
                            r_en   <= 1'b1;
                            r_cnt  <= r_cnt + CNT_ONE;
                        end
                    end else if (r_state == S_STEP && !w_hit) begin
                        r_en  <= 1'b1;
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_state <= S_IDLE;
                        r_en    <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.sel  = r_sel;
    assign bus.en   = r_en;
    assign bus.tick = r_tick;
    assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: each cycle's expected outputs are queued
// with the stimulus and compared one clock later.
module tb_scan_sequencer;
    logic clk;
    logic rst_n;

    scan_sequencer_if #(.PRESCALE_W(4)) sif ();

    scan_sequencer #(.PRESCALE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    typedef struct {
        int sel;
        int en;
        int tick;
        int wrap;
    } exp_t;

    exp_t sb[$];
    int   n_tot = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Queue the expectation for the coming edge, clock once, then score it.
    task automatic pe(input int s, input int e, input int t, input int w);
        exp_t x;
        sb.push_back('{s, e, t, w});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("sel",  int'(sif.sel),  x.sel);
        chk("en",   int'(sif.en),   x.en);
        chk("tick", int'(sif.tick), x.tick);
        chk("wrap", int'(sif.wrap), x.wrap);
        chk("en_tick_excl", int'(sif.en & sif.tick), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sif.run  = 1'b0;
        sif.step = 1'b0;
        sif.last = 3'd7;
        sif.div  = 4'd2;
        #12;
        chk("rst_sel",  int'(sif.sel),  0);
        chk("rst_en",   int'(sif.en),   0);
        chk("rst_tick", int'(sif.tick), 0);
        chk("rst_wrap", int'(sif.wrap), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) pe(0, 0, 0, 0);

        // free run, div=2 last=7: first dwell is div+1 enabled, then blank,en,en
        sif.run = 1'b1;
        for (int i = 0; i < 3; i++) pe(0, 1, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            pe(k % 8, 0, 1, (k % 8 == 0) ? 1 : 0);
            if (k < 9) begin
                pe(k % 8, 1, 0, 0);
                pe(k % 8, 1, 0, 0);
            end
        end
        pe(1, 1, 0, 0);
        sif.run = 1'b0;
        for (int i = 0; i < 3; i++) pe(1, 0, 0, 0);

        // short cycle div=1 last=2, then last lowered to 1 while sel=2
        sif.div  = 4'd1;
        sif.last = 3'd2;
        sif.run  = 1'b1;
        pe(1, 1, 0, 0); pe(1, 1, 0, 0); pe(2, 0, 1, 0); pe(2, 1, 0, 0);
        pe(0, 0, 1, 1); pe(0, 1, 0, 0); pe(1, 0, 1, 0); pe(1, 1, 0, 0);
        pe(2, 0, 1, 0);
        sif.last = 3'd1;
        pe(2, 1, 0, 0); pe(0, 0, 1, 1); pe(0, 1, 0, 0); pe(1, 0, 1, 0);
        pe(1, 1, 0, 0); pe(0, 0, 1, 1);
        sif.run = 1'b0;
        pe(0, 0, 0, 0);

        // walk to sel=5 with div=0 single steps (zero enabled cycles each)
        sif.last = 3'd7;
        sif.div  = 4'd0;
        for (int s = 0; s < 5; s++) begin
            sif.step = 1'b1;
            pe(s + 1, 0, 1, 0);
            sif.step = 1'b0;
            pe(s + 1, 0, 0, 0);
        end

        // div=3 single step from 5; a second pulse mid-dwell is ignored
        sif.div  = 4'd3;
        sif.step = 1'b1;
        pe(6, 0, 1, 0);
        sif.step = 1'b0;
        pe(6, 1, 0, 0);
        sif.step = 1'b1;
        pe(6, 1, 0, 0);
        sif.step = 1'b0;
        pe(6, 1, 0, 0);
        pe(6, 0, 0, 0);
        pe(6, 0, 0, 0);

        // run and step together in IDLE: run wins, no immediate advance
        sif.run  = 1'b1;
        sif.step = 1'b1;
        pe(6, 1, 0, 0);
        sif.step = 1'b0;
        for (int i = 0; i < 3; i++) pe(6, 1, 0, 0);
        pe(7, 0, 1, 0);
        sif.run = 1'b0;
        pe(7, 0, 0, 0);

        // step wraps 7->0, then run rises during STEP with count continuing
        sif.step = 1'b1;
        pe(0, 0, 1, 1);
        sif.step = 1'b0;
        pe(0, 1, 0, 0);
        sif.run = 1'b1;
        pe(0, 1, 0, 0); pe(0, 1, 0, 0); pe(1, 0, 1, 0);
        for (int i = 0; i < 3; i++) pe(1, 1, 0, 0);
        pe(2, 0, 1, 0);

        // div=0 while running: advance every cycle, en stays low
        sif.div = 4'd0;
        for (int k = 3; k <= 8; k++) pe(k % 8, 0, 1, (k % 8 == 0) ? 1 : 0);

        // div lowered below count: count rolls over mod 16 before matching
        sif.div = 4'd5;
        for (int i = 0; i < 4; i++) pe(0, 1, 0, 0);
        sif.div = 4'd2;
        for (int i = 0; i < 14; i++) pe(0, 1, 0, 0);
        pe(1, 0, 1, 0);

        // scan on to sel=4 with en=1, then async reset between edges
        pe(1, 1, 0, 0); pe(1, 1, 0, 0); pe(2, 0, 1, 0); pe(2, 1, 0, 0);
        pe(2, 1, 0, 0); pe(3, 0, 1, 0); pe(3, 1, 0, 0); pe(3, 1, 0, 0);
        pe(4, 0, 1, 0); pe(4, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel",  int'(sif.sel),  0);
        chk("arst_en",   int'(sif.en),   0);
        chk("arst_tick", int'(sif.tick), 0);
        chk("arst_wrap", int'(sif.wrap), 0);
        chk("sb_empty",  sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
